// File: rtl/fetch_unit.sv
// Instruction fetch requester: issues sequential word reads to a 1-cycle-latency
// program memory and queues returned words for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  // Handshake: the head entry transfers in any cycle where inst_valid and
  // inst_ready are both 1 at the rising edge; a redirect in that cycle cancels it.

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0]   START_PC = RESET_PC & ~32'h3;
  localparam logic [CW-1:0] DEPTH_CW = CW'(BUF_DEPTH);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   issued_pc;
  logic          inflight;
  logic          kill;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  always_comb begin
    pop       = inst_valid & inst_ready & ~redirect_valid;
    push      = inflight & ~kill & ~redirect_valid;
    // Slots that will be spoken for after this cycle, before any new issue.
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight}
              - {{CW{1'b0}}, (inst_valid & inst_ready)};
    issue     = (state == RUN) & fetch_en & ~redirect_valid
              & (occupancy < {1'b0, DEPTH_CW});
    rd_next   = rd_ptr + PW'(1);
  end

  assign mem_read       = issue;
  assign mem_address    = fetch_pc;
  assign mem_write      = 1'b0;
  assign mem_write_data = 32'h0;
  assign inst_valid     = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOP;
      fetch_pc  <= START_PC;
      issued_pc <= 32'h0;
      inflight  <= 1'b0;
      kill      <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      inst_data <= 32'h0;
      inst_pc   <= 32'h0;
    end else begin
      case (state)
        STOP: if (fetch_en)  state <= RUN;
        RUN:  if (!fetch_en) state <= STOP;
        default: state <= STOP;
      endcase

      inflight <= issue;
      kill     <= redirect_valid & inflight;

      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (issue) begin
        fetch_pc  <= fetch_pc + 32'd4;
        issued_pc <= fetch_pc;
      end

      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_next;
        // Head registers: next stored entry, or the arriving word if the buffer drains to it.
        if (pop && count > CW'(1)) begin
          inst_data <= buf_data[rd_next];
          inst_pc   <= buf_pc[rd_next];
        end else if (push && (count == '0 || (pop && count == CW'(1)))) begin
          inst_data <= mem_read_data;
          inst_pc   <= issued_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= mem_read_data;
      buf_pc[wr_ptr]   <= issued_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop)
      assert (count != DEPTH_CW) else $error("fetch_unit: push into full instruction buffer");
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// a sequential-address reference model of the fetch and delivery streams.
module tb_fetch_unit;

  localparam int BUF_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory contents: words 0..3 are 0xA0..0xA3, the rest address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w < 32'h10) return 32'hA0 + (w >> 2);
    return w ^ 32'hC3C3_0000;
  endfunction

  initial mem_read_data = 32'h0;
  always @(posedge clk) if (mem_read) mem_read_data <= mem_word(mem_address);

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    fetch_en       = fe;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_issue;
  logic [31:0] exp_pop;
  int          outstanding;
  int          drain_pops;
  logic        fe_r;
  logic        rdy_r;
  logic        rv_r;
  logic [31:0] rpc_r;

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    check("reset_mem_read", {31'b0, mem_read}, 32'd0);
    check("reset_mem_address", mem_address, 32'h0);
    check("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("reset_inst_data", inst_data, 32'h0);
    check("reset_inst_pc", inst_pc, 32'h0);
    check("mem_write_const", {31'b0, mem_write}, 32'd0);
    check("mem_wdata_const", mem_write_data, 32'h0);

    // Streaming with decode always ready
    do_reset();
    step(1, 1, 0, 0);
    check("stream_stop_cycle", {31'b0, mem_read}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      if (i < 4) begin
        check("stream_mem_read", {31'b0, mem_read}, 32'd1);
        check("stream_addr", mem_address, 32'(4 * i));
      end
      if (i < 2) begin
        check("stream_valid_startup", {31'b0, inst_valid}, 32'd0);
      end else begin
        check("stream_valid", {31'b0, inst_valid}, 32'd1);
        check("stream_data", inst_data, 32'hA0 + 32'(i - 2));
        check("stream_pc", inst_pc, 32'(4 * (i - 2)));
      end
    end

    // Backpressure fills the buffer, then release
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("bp_issue0", mem_address, 32'h0);
    check("bp_read0", {31'b0, mem_read}, 32'd1);
    step(1, 0, 0, 0);
    check("bp_issue1", mem_address, 32'h4);
    check("bp_read1", {31'b0, mem_read}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("bp_no_issue", {31'b0, mem_read}, 32'd0);
      check("bp_valid", {31'b0, inst_valid}, 32'd1);
      check("bp_hold_data", inst_data, 32'hA0);
      check("bp_hold_pc", inst_pc, 32'h0);
    end
    step(1, 1, 0, 0);
    check("bp_resume_read", {31'b0, mem_read}, 32'd1);
    check("bp_resume_addr", mem_address, 32'h8);
    check("bp_resume_head", inst_data, 32'hA0);
    step(1, 1, 0, 0);
    check("bp_second_data", inst_data, 32'hA1);
    check("bp_second_pc", inst_pc, 32'h4);
    check("bp_next_addr", mem_address, 32'hC);

    // Redirect while streaming
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h43);
    check("redir_addr_before", mem_address, 32'h10);
    check("redir_no_issue", {31'b0, mem_read}, 32'd0);
    step(1, 1, 0, 0);
    check("redir_flushed", {31'b0, inst_valid}, 32'd0);
    check("redir_new_read", {31'b0, mem_read}, 32'd1);
    check("redir_new_addr", mem_address, 32'h40);
    step(1, 1, 0, 0);
    check("redir_still_empty", {31'b0, inst_valid}, 32'd0);
    check("redir_addr_44", mem_address, 32'h44);
    step(1, 1, 0, 0);
    check("redir_head_valid", {31'b0, inst_valid}, 32'd1);
    check("redir_head_pc", inst_pc, 32'h40);
    check("redir_head_data", inst_data, mem_word(32'h40));
    step(1, 1, 0, 0);
    check("redir_next_pc", inst_pc, 32'h44);

    // fetch_en dropped after issuing 0x8
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("fe_issue8", mem_address, 32'h8);
    step(0, 1, 0, 0);
    check("fe_off_no_read", {31'b0, mem_read}, 32'd0);
    step(0, 1, 0, 0);
    check("fe_off_no_read2", {31'b0, mem_read}, 32'd0);
    check("fe_inflight_pc", inst_pc, 32'h8);
    check("fe_inflight_data", inst_data, 32'hA2);
    step(0, 1, 0, 0);
    check("fe_drained", {31'b0, inst_valid}, 32'd0);
    step(1, 1, 0, 0);
    check("fe_restart_stop", {31'b0, mem_read}, 32'd0);
    step(1, 1, 0, 0);
    check("fe_resume_read", {31'b0, mem_read}, 32'd1);
    check("fe_resume_addr", mem_address, 32'hC);

    // Address wrap
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFFF);
    check("wrap_redir_no_read", {31'b0, mem_read}, 32'd0);
    step(1, 1, 0, 0);
    check("wrap_addr_top", mem_address, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    check("wrap_addr_zero", mem_address, 32'h0);
    check("wrap_read_zero", {31'b0, mem_read}, 32'd1);
    step(1, 1, 0, 0);
    check("wrap_head_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_head_data", inst_data, mem_word(32'hFFFF_FFFC));
    step(1, 1, 0, 0);
    check("wrap_next_pc", inst_pc, 32'h0);

    // Reset asserted mid-operation with a buffered word and one in flight
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("mid_valid_before", {31'b0, inst_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    check("mid_rst_read", {31'b0, mem_read}, 32'd0);
    check("mid_rst_addr", mem_address, 32'h0);
    check("mid_rst_data", inst_data, 32'h0);
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    check("mid_rel_stop", {31'b0, mem_read}, 32'd0);
    check("mid_rel_empty", {31'b0, inst_valid}, 32'd0);
    step(1, 1, 0, 0);
    check("mid_rel_first_addr", mem_address, 32'h0);
    check("mid_rel_first_read", {31'b0, mem_read}, 32'd1);
    step(1, 1, 0, 0);
    check("mid_rel_still_empty", {31'b0, inst_valid}, 32'd0);
    step(1, 1, 0, 0);
    check("mid_rel_head_pc", inst_pc, 32'h0);
    check("mid_rel_head_data", inst_data, 32'hA0);

    // Randomized run against the address-stream model
    do_reset();
    exp_issue   = 32'h0;
    exp_pop     = 32'h0;
    outstanding = 0;
    drain_pops  = 0;
    for (int n = 0; n < 3012; n++) begin
      if (n < 3000) begin
        fe_r  = ($urandom_range(0, 7) != 0);
        rdy_r = $urandom_range(0, 1) != 0;
        rv_r  = ($urandom_range(0, 24) == 0);
        rpc_r = $urandom;
      end else begin
        fe_r = 1'b1; rdy_r = 1'b1; rv_r = 1'b0; rpc_r = 32'h0;
      end
      step(fe_r, rdy_r, rv_r, rpc_r);
      if (mem_read) begin
        check("rnd_issue_allowed", {30'b0, fe_r, rv_r}, 32'd2);
        check("rnd_issue_addr", mem_address, exp_issue);
        exp_issue = exp_issue + 32'd4;
        outstanding++;
      end
      if (rv_r) begin
        exp_issue   = rpc_r & ~32'h3;
        exp_pop     = rpc_r & ~32'h3;
        outstanding = 0;
      end else if (inst_valid && rdy_r) begin
        check("rnd_pop_pc", inst_pc, exp_pop);
        check("rnd_pop_data", inst_data, mem_word(exp_pop));
        exp_pop = exp_pop + 32'd4;
        outstanding--;
        if (n >= 3000) drain_pops++;
      end
      check("rnd_occupancy", {31'b0, (outstanding <= BUF_DEPTH)}, 32'd1);
    end
    check("rnd_drain_progress", {31'b0, (drain_pops >= 8)}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
